// File: rtl/instr_encoder_rv32i.sv
// RV32I instruction encoder: packs decoded operation requests into 32-bit words
// and queues them in a first-word-fall-through FIFO; illegal requests are dropped and flagged.
module instr_encoder_rv32i #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [2:0]  req_func3,
    input  logic [6:0]  req_func7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [31:0] enc_cnt
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          err_reg;
    logic [31:0]   enc_cnt_reg;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        f7_base;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;

    // f7_base: func7 is one of the two encodings the base ISA defines
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        f7_base   = (req_func7 == 7'b0000000) || (req_func7 == 7'b0100000);
        case (req_kind)
            3'd0: begin
                enc_legal = f7_base;
                enc_word  = {req_func7, req_rs2, req_rs1, req_func3, req_rd, OP_R};
            end
            3'd1: begin
                if (req_func3 == 3'b001 || req_func3 == 3'b101) begin
                    // Only srai may carry func7=0100000; slli with it is undefined
                    enc_legal = f7_base && !(req_func3 == 3'b001 && req_func7[5]);
                    enc_word  = {req_func7, req_imm[4:0], req_rs1, req_func3, req_rd, OP_I_ALU};
                end else begin
                    enc_word  = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_I_ALU};
                end
            end
            3'd2: begin
                enc_legal = !(req_func3 == 3'b011 || req_func3 == 3'b110 || req_func3 == 3'b111);
                enc_word  = {req_imm[11:0], req_rs1, req_func3, req_rd, OP_LOAD};
            end
            3'd3: begin
                enc_legal = (req_func3 < 3'b011);
                enc_word  = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], OP_STORE};
            end
            3'd4: begin
                enc_legal = !(req_func3 == 3'b010 || req_func3 == 3'b011) && !req_imm[0];
                enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                             req_imm[4:1], req_imm[11], OP_BRANCH};
            end
            3'd5: begin
                enc_legal = !req_imm[0];
                enc_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            3'd6: begin
                enc_word  = {req_imm[31:12], req_rd, OP_LUI};
            end
            default: begin
                enc_word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            end
        endcase
    end

    assign full      = (count_reg == (AW + 1)'(DEPTH));
    assign req_ready = !rst && !full;
    assign out_valid = (count_reg != '0);
    assign out_instr = mem[rd_ptr_reg];
    assign accept    = req_valid && req_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;
    assign err       = err_reg;
    assign enc_cnt   = enc_cnt_reg;

    // Storage has no reset: contents are invisible until occupancy says otherwise
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
            enc_cnt_reg <= 32'd0;
        end else begin
            err_reg <= accept && !enc_legal;
            if (push) begin
                wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                enc_cnt_reg <= enc_cnt_reg + 32'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_rv32i.sv
// Self-checking bench for instr_encoder_rv32i: directed test-plan cases with literal
// expectations, then randomized traffic compared every cycle against a queue-based model.
module tb_instr_encoder_rv32i;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [2:0]  req_func3;
    logic [6:0]  req_func7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [31:0] enc_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] m_cnt = 32'd0;
    bit          m_err = 1'b0;

    instr_encoder_rv32i #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_func3(req_func3), .req_func7(req_func7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err(err), .enc_cnt(enc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_legal(input int unsigned kind, input int unsigned f3,
                                   input int unsigned f7, input int unsigned imm);
        case (kind)
            0: return f7 == 0 || f7 == 32;
            1: begin
                if (f3 == 1) return f7 == 0;
                if (f3 == 5) return f7 == 0 || f7 == 32;
                return 1'b1;
            end
            2: return !(f3 == 3 || f3 == 6 || f3 == 7);
            3: return f3 < 3;
            4: return f3 != 2 && f3 != 3 && (imm % 2) == 0;
            5: return (imm % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_enc(input int unsigned kind, input int unsigned f3,
                                          input int unsigned f7, input int unsigned rd,
                                          input int unsigned rs1, input int unsigned rs2,
                                          input int unsigned im);
        int unsigned regs;
        regs = rs1 * 32768 + f3 * 4096;
        case (kind)
            0: return f7 * 33554432 + rs2 * 1048576 + regs + rd * 128 + 'h33;
            1: begin
                if (f3 == 1 || f3 == 5)
                    return f7 * 33554432 + (im % 32) * 1048576 + regs + rd * 128 + 'h13;
                return (im % 4096) * 1048576 + regs + rd * 128 + 'h13;
            end
            2: return (im % 4096) * 1048576 + regs + rd * 128 + 'h03;
            3: return ((im / 32) % 128) * 33554432 + rs2 * 1048576 + regs + (im % 32) * 128 + 'h23;
            4: return ((im / 4096) % 2) * 32'h8000_0000 + ((im / 32) % 64) * 33554432
                      + rs2 * 1048576 + regs + ((im / 2) % 16) * 256 + ((im / 2048) % 2) * 128 + 'h63;
            5: return ((im / 1048576) % 2) * 32'h8000_0000 + ((im / 2) % 1024) * 2097152
                      + ((im / 2048) % 2) * 1048576 + ((im / 4096) % 256) * 4096 + rd * 128 + 'h6F;
            6: return (im / 4096) * 4096 + rd * 128 + 'h37;
            default: return (im % 4096) * 1048576 + rs1 * 32768 + rd * 128 + 'h67;
        endcase
    endfunction

    // One clock: predict from current inputs, advance model at the edge, compare at negedge
    task automatic tick();
        bit          acc;
        bit          pop;
        bit          lg;
        logic [31:0] w;
        acc = req_valid && !rst && (q.size() < DEPTH);
        pop = (q.size() > 0) && out_ready;
        lg  = m_legal(req_kind, req_func3, req_func7, req_imm);
        w   = m_enc(req_kind, req_func3, req_func7, req_rd, req_rs1, req_rs2, req_imm);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 32'd0;
            m_err = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            m_err = acc && !lg;
            if (acc && lg) begin
                q.push_back(w);
                m_cnt++;
            end
            if (acc) $display("t=%0t req kind=%0d f3=%0d f7=%h imm=%h legal=%0d word=%h",
                              $time, req_kind, req_func3, req_func7, req_imm, lg, w);
        end
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("req_ready", {31'd0, req_ready}, {31'd0, !rst && (q.size() < DEPTH)});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("enc_cnt", enc_cnt, m_cnt);
        if (q.size() != 0) chk("out_instr", out_instr, q[0]);
    endtask

    task automatic set_req(input int unsigned kind, input int unsigned f3, input int unsigned f7,
                           input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
                           input logic [31:0] imm);
        req_valid = 1'b1;
        req_kind  = 3'(kind);
        req_func3 = 3'(f3);
        req_func7 = 7'(f7);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = imm;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 32'd0);
        req_valid = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_enc_cnt", enc_cnt, 32'd0);
        rst = 1'b0;

        // add x3,x1,x2
        set_req(0, 0, 0, 3, 1, 2, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("add_word", out_instr, 32'h002081B3);
        chk("add_cnt", enc_cnt, 32'd1);
        drain();

        // sub x3,x1,x2 then addi x5,x0,-1
        set_req(0, 0, 7'h20, 3, 1, 2, 32'd0);
        tick();
        set_req(1, 0, 0, 5, 0, 0, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        chk("sub_word", out_instr, 32'h402081B3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("addi_word", out_instr, 32'hFFF00293);
        drain();

        // sw x2,8(x1) then beq x1,x2,+8
        set_req(3, 2, 0, 0, 1, 2, 32'd8);
        tick();
        set_req(4, 0, 0, 0, 1, 2, 32'd8);
        tick();
        req_valid = 1'b0;
        chk("sw_word", out_instr, 32'h0020A423);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("beq_word", out_instr, 32'h00208463);
        drain();

        // illegal odd branch offset between two legal requests
        do_reset();
        set_req(0, 0, 0, 3, 1, 2, 32'd0);
        tick();
        set_req(4, 0, 0, 0, 1, 2, 32'd7);
        tick();
        chk("illegal_err_hi", {31'd0, err}, 32'd1);
        set_req(1, 0, 0, 5, 0, 0, 32'hFFFF_FFFF);
        tick();
        chk("illegal_err_lo", {31'd0, err}, 32'd0);
        chk("illegal_cnt", enc_cnt, 32'd2);
        req_valid = 1'b0;
        chk("illegal_head", out_instr, 32'h002081B3);
        drain();

        // fill to DEPTH with consumer stalled, then release one slot
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(1, 0, 0, i + 1, 0, 0, 32'(i));
            tick();
        end
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("full_cnt", enc_cnt, 32'd4);
        out_ready = 1'b1;
        tick();
        chk("after_pop_ready", {31'd0, req_ready}, 32'd1);
        out_ready = 1'b0;
        tick();
        chk("fifth_cnt", enc_cnt, 32'd5);
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        set_req(6, 0, 0, 7, 0, 0, 32'h1234_5000);
        tick();
        chk("pushpop_ready", {31'd0, req_ready}, 32'd1);
        drain();

        // reset with words queued flushes them
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 0, 0, i + 1, 1, 2, 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cnt", enc_cnt, 32'd0);
        chk("flush_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        set_req(5, 0, 0, 1, 0, 0, 32'd16);
        tick();
        req_valid = 1'b0;
        chk("jal_word", out_instr, 32'h010000EF);
        out_ready = 1'b1;
        tick();
        chk("jal_alone", {31'd0, out_valid}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned sel;
            rst = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 3);
            set_req($urandom_range(0, 7), $urandom_range(0, 7),
                    (sel == 0) ? 32'h20 : ((sel == 1) ? $urandom_range(0, 127) : 0),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom);
            if ($urandom_range(0, 3) != 0) req_imm[0] = 1'b0;
            req_valid = ($urandom_range(0, 3) != 0);
            if (((i / 100) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
